// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: funnels per-thread LSU load/store ports onto memory channels.
// Optional MEM_ARB_ROUND_ROBIN_EN: rotating claim priority (default: fixed, port 0 first).
module lsu_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_WRITE_WAIT,
        S_READ_RELAY,
        S_WRITE_RELAY
    } state_t;

    state_t                           r_state   [NUM_CHANNELS];
    state_t                           w_state_n [NUM_CHANNELS];
    logic [PW-1:0]                    r_port    [NUM_CHANNELS];
    logic [PW-1:0]                    w_port_n  [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0]         r_serving;
    logic [NUM_CONSUMERS-1:0]         w_serving_n;
    logic [NUM_CONSUMERS-1:0]         w_taken;

    logic [NUM_CHANNELS-1:0]          r_mrv;
    logic [NUM_CHANNELS-1:0]          w_mrv_n;
    logic [NUM_CHANNELS-1:0]          r_mwv;
    logic [NUM_CHANNELS-1:0]          w_mwv_n;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] r_mra;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] w_mra_n;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] r_mwa;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] w_mwa_n;
    logic [NUM_CHANNELS*DATA_BITS-1:0] r_mwd;
    logic [NUM_CHANNELS*DATA_BITS-1:0] w_mwd_n;

    logic [NUM_CONSUMERS-1:0]          r_crr;
    logic [NUM_CONSUMERS-1:0]          w_crr_n;
    logic [NUM_CONSUMERS-1:0]          r_cwr;
    logic [NUM_CONSUMERS-1:0]          w_cwr_n;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_crd;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] w_crd_n;

    int   w_start;
    int   w_idx;
    int   w_sel;
    int   w_p;
    logic w_found;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_n;
`endif

    assign consumer_read_ready  = r_crr;
    assign consumer_read_data   = r_crd;
    assign consumer_write_ready = r_cwr;
    assign mem_read_valid       = r_mrv;
    assign mem_read_address     = r_mra;
    assign mem_write_valid      = r_mwv;
    assign mem_write_address    = r_mwa;
    assign mem_write_data       = r_mwd;

    // Channel FSMs: claim scan, memory handshake and consumer relay (next-state logic)
    always_comb begin
        w_state_n   = r_state;
        w_port_n    = r_port;
        w_serving_n = r_serving;
        w_taken     = r_serving;
        w_mrv_n     = r_mrv;
        w_mwv_n     = r_mwv;
        w_mra_n     = r_mra;
        w_mwa_n     = r_mwa;
        w_mwd_n     = r_mwd;
        w_crr_n     = r_crr;
        w_cwr_n     = r_cwr;
        w_crd_n     = r_crd;
        w_idx       = 0;
        w_sel       = 0;
        w_p         = 0;
        w_found     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_ptr_n     = r_ptr;
        w_start     = int'(r_ptr);
`else
        w_start     = 0;
`endif
        // Lower channel indices claim first; w_taken hides their picks
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_p = int'(r_port[c]);
            unique case (r_state[c])
                S_IDLE: begin
                    w_found = 1'b0;
                    w_sel   = 0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        w_idx = w_start + k;
                        if (w_idx >= NUM_CONSUMERS)
                            w_idx = w_idx - NUM_CONSUMERS;
                        if (!w_found && !w_taken[w_idx] &&
                            (consumer_read_valid[w_idx] ||
                             consumer_write_valid[w_idx])) begin
                            w_found = 1'b1;
                            w_sel   = w_idx;
                        end
                    end
                    if (w_found) begin
                        w_taken[w_sel]     = 1'b1;
                        w_serving_n[w_sel] = 1'b1;
                        w_port_n[c]        = PW'(w_sel);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        w_ptr_n = PW'((w_sel + 1) % NUM_CONSUMERS);
`endif
                        // A port asking for both gets its load first
                        if (consumer_read_valid[w_sel]) begin
                            w_mrv_n[c] = 1'b1;
                            w_mra_n[c*ADDR_BITS +: ADDR_BITS] =
                                consumer_read_address[w_sel*ADDR_BITS +: ADDR_BITS];
                            w_state_n[c] = S_READ_WAIT;
                        end else begin
                            w_mwv_n[c] = 1'b1;
                            w_mwa_n[c*ADDR_BITS +: ADDR_BITS] =
                                consumer_write_address[w_sel*ADDR_BITS +: ADDR_BITS];
                            w_mwd_n[c*DATA_BITS +: DATA_BITS] =
                                consumer_write_data[w_sel*DATA_BITS +: DATA_BITS];
                            w_state_n[c] = S_WRITE_WAIT;
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        w_mrv_n[c] = 1'b0;
                        w_crr_n[w_p] = 1'b1;
                        w_crd_n[w_p*DATA_BITS +: DATA_BITS] =
                            mem_read_data[c*DATA_BITS +: DATA_BITS];
                        w_state_n[c] = S_READ_RELAY;
                    end
                end
                S_WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        w_mwv_n[c]   = 1'b0;
                        w_cwr_n[w_p] = 1'b1;
                        w_state_n[c] = S_WRITE_RELAY;
                    end
                end
                S_READ_RELAY: begin
                    if (!consumer_read_valid[w_p]) begin
                        w_crr_n[w_p]     = 1'b0;
                        w_serving_n[w_p] = 1'b0;
                        w_state_n[c]     = S_IDLE;
                    end
                end
                S_WRITE_RELAY: begin
                    if (!consumer_write_valid[w_p]) begin
                        w_cwr_n[w_p]     = 1'b0;
                        w_serving_n[w_p] = 1'b0;
                        w_state_n[c]     = S_IDLE;
                    end
                end
                default: begin
                    w_state_n[c] = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset abandons any outstanding memory op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= S_IDLE;
                r_port[c]  <= '0;
            end
            r_serving <= '0;
            r_mrv     <= '0;
            r_mwv     <= '0;
            r_mra     <= '0;
            r_mwa     <= '0;
            r_mwd     <= '0;
            r_crr     <= '0;
            r_cwr     <= '0;
            r_crd     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_ptr     <= '0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_port    <= w_port_n;
            r_serving <= w_serving_n;
            r_mrv     <= w_mrv_n;
            r_mwv     <= w_mwv_n;
            r_mra     <= w_mra_n;
            r_mwa     <= w_mwa_n;
            r_mwd     <= w_mwd_n;
            r_crr     <= w_crr_n;
            r_cwr     <= w_cwr_n;
            r_crd     <= w_crd_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_ptr     <= w_ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed checks of lsu_mem_arbiter, one- and two-channel builds.
// Grant-order expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_lsu_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  a_rv, a_rr, a_wv, a_wr;
    logic [31:0] a_ra, a_rd, a_wa, a_wd;
    logic [0:0]  a_mrv, a_mrr, a_mwv, a_mwr;
    logic [7:0]  a_mra, a_mrd, a_mwa, a_mwd;

    logic [3:0]  b_rv, b_rr, b_wv, b_wr;
    logic [31:0] b_ra, b_rd, b_wa, b_wd;
    logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
    logic [15:0] b_mra, b_mrd, b_mwa, b_mwd;

    int exp_g [5];

    lsu_mem_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)
    ) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    lsu_mem_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)
    ) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        reset = 1'b1;
        a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0;
        #12;
        chk("rst_mrv", 32'(a_mrv), 32'h0);
        chk("rst_mwv", 32'(a_mwv), 32'h0);
        chk("rst_rr", 32'(a_rr), 32'h0);
        chk("rst_wr", 32'(a_wr), 32'h0);
        chk("rst_rd", a_rd, 32'h0);
        chk("rst_b_mrv", 32'(b_mrv), 32'h0);

        // port 2 load, memory answers after 3 cycles
        reset = 1'b0;
        a_rv[2] = 1'b1;
        a_ra[16 +: 8] = 8'h10;
        step();
        chk("rd_mrv", 32'(a_mrv), 32'h1);
        chk("rd_mra", 32'(a_mra), 32'h10);
        step();
        step();
        chk("rd_wait_mrv", 32'(a_mrv), 32'h1);
        chk("rd_wait_rr", 32'(a_rr), 32'h0);
        a_mrr = 1'b1;
        a_mrd = 8'hA5;
        step();
        chk("rd_rr", 32'(a_rr), 32'h4);
        chk("rd_data", 32'(a_rd[16 +: 8]), 32'hA5);
        chk("rd_mrv_low", 32'(a_mrv), 32'h0);
        a_mrr = 1'b0;
        a_mrd = 8'h00;
        step();
        step();
        chk("rd_hold_rr", 32'(a_rr), 32'h4);
        chk("rd_no_reclaim", 32'(a_mrv), 32'h0);
        a_rv[2] = 1'b0;
        step();
        chk("rd_drop_rr", 32'(a_rr), 32'h0);
        chk("rd_data_keep", 32'(a_rd[16 +: 8]), 32'hA5);

        // port 1 store
        a_wv[1] = 1'b1;
        a_wa[8 +: 8] = 8'h22;
        a_wd[8 +: 8] = 8'h7E;
        step();
        chk("wr_mwv", 32'(a_mwv), 32'h1);
        chk("wr_mwa", 32'(a_mwa), 32'h22);
        chk("wr_mwd", 32'(a_mwd), 32'h7E);
        chk("wr_wr_early", 32'(a_wr), 32'h0);
        a_mwr = 1'b1;
        step();
        chk("wr_wr", 32'(a_wr), 32'h2);
        chk("wr_mwv_low", 32'(a_mwv), 32'h0);
        a_mwr = 1'b0;
        a_wv[1] = 1'b0;
        step();
        chk("wr_drop_wr", 32'(a_wr), 32'h0);

        // port 2 claimable again
        a_rv[2] = 1'b1;
        a_ra[16 +: 8] = 8'h12;
        step();
        chk("rd2_mra", 32'(a_mra), 32'h12);
        a_mrr = 1'b1;
        a_mrd = 8'h3C;
        step();
        chk("rd2_data", 32'(a_rd[16 +: 8]), 32'h3C);
        a_mrr = 1'b0;
        a_rv[2] = 1'b0;
        step();

        // reset while a load is outstanding
        a_rv[0] = 1'b1;
        a_ra[0 +: 8] = 8'h33;
        step();
        chk("mid_mrv", 32'(a_mrv), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_mrv", 32'(a_mrv), 32'h0);
        chk("mid_rst_mra", 32'(a_mra), 32'h0);
        chk("mid_rst_rd", a_rd, 32'h0);
        #2;
        reset = 1'b0;
        a_ra[0 +: 8] = 8'h44;
        step();
        chk("post_mrv", 32'(a_mrv), 32'h1);
        chk("post_mra", 32'(a_mra), 32'h44);
        a_mrr = 1'b1;
        a_mrd = 8'h5C;
        step();
        chk("post_rr", 32'(a_rr), 32'h1);
        chk("post_data", 32'(a_rd[0 +: 8]), 32'h5C);
        a_mrr = 1'b0;
        a_rv[0] = 1'b0;
        step();
        chk("post_drop", 32'(a_rr), 32'h0);

        // all ports loading continuously: grant order
        reset = 1'b1;
        #1;
        reset = 1'b0;
        a_ra = 32'h83828180;
        a_rv = 4'hF;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("arb_mrv", 32'(a_mrv), 32'h1);
            chk("arb_mra", 32'(a_mra), 32'(8'h80 + 8'(exp_g[g])));
            a_mrr = 1'b1;
            a_mrd = 8'(8'hC0 + g);
            step();
            chk("arb_rr", 32'(a_rr), 32'(4'b0001 << exp_g[g]));
            chk("arb_data", 32'(a_rd[exp_g[g]*8 +: 8]), 32'(8'hC0 + g));
            a_mrr = 1'b0;
            a_rv[exp_g[g]] = 1'b0;
            step();
            chk("arb_drop", 32'(a_rr), 32'h0);
            if (g < 4)
                a_rv[exp_g[g]] = 1'b1;
            else
                a_rv = '0;
        end

        // two channels, ports 0 and 3 in the same cycle
        b_ra[0 +: 8]  = 8'h01;
        b_ra[24 +: 8] = 8'h03;
        b_rv = 4'b1001;
        step();
        chk("dual_mrv", 32'(b_mrv), 32'h3);
        chk("dual_mra", 32'(b_mra), 32'h0301);
        b_mrr = 2'b11;
        b_mrd = 16'h3311;
        step();
        chk("dual_rr", 32'(b_rr), 32'h9);
        chk("dual_d0", 32'(b_rd[0 +: 8]), 32'h11);
        chk("dual_d3", 32'(b_rd[24 +: 8]), 32'h33);
        b_mrr = 2'b00;
        step();
        chk("dual_no_double", 32'(b_mrv), 32'h0);
        b_rv = '0;
        step();
        chk("dual_drop", 32'(b_rr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
